// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the barrel-shift arbiter: FSM state encoding,
// default datapath widths and a reference rotate-left helper.
package barrel_shift_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int WIDTH_D = 8;
   localparam int SHW_D   = 3;

   // The upper half of {x,x}<<n holds x rotated left by n, so no bit is lost.
   function automatic logic [WIDTH_D-1:0] rotl(input logic [WIDTH_D-1:0] x,
                                                input logic [SHW_D-1:0]   n);
      logic [2*WIDTH_D-1:0] dbl;
      dbl = {x, x} << n;
      return dbl[2*WIDTH_D-1 -: WIDTH_D];
   endfunction

endpackage

// File: rtl/barrel_shift_arb_rot_core.sv
// Combinational WIDTH-bit rotate-left; WIDTH must equal 2**SHW so the
// source index wraps naturally in SHW-bit arithmetic.
module rot_core #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic [WIDTH-1:0] din,
   input  logic [SHW-1:0]   amt,
   output logic [WIDTH-1:0] dout
);

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic [SHW-1:0] src;
         // Output bit gi comes from input bit (gi - amt) mod WIDTH.
         assign src      = SHW'(gi) - amt;
         assign dout[gi] = din[src];
      end
   endgenerate

endmodule

// File: rtl/barrel_shift_arb.sv
// Arbitrates NREQ requesters onto one shared rotate-left shifter and returns
// tagged results. Define BARREL_SHIFT_ARB_FIXED_PRIO_EN for fixed priority.
module barrel_shift_arb
   import barrel_shift_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = WIDTH_D,
   parameter int SHW   = SHW_D,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ*SHW-1:0]   req_amt,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic [IDW-1:0]        rsp_id,
   output logic                  busy
);

   state_t           state_reg;
   logic [WIDTH-1:0] op_reg;
   logic [SHW-1:0]   amt_reg;
   logic [IDW-1:0]   id_reg;
   logic             rsp_valid_reg;
   logic [WIDTH-1:0] rsp_data_reg;
   logic [IDW-1:0]   rsp_id_reg;
`ifndef BARREL_SHIFT_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]   rr_ptr_reg;
`endif

   logic             accept;
   logic             grant_any;
   logic [IDW-1:0]   grant_id;
   logic             take;
   logic [WIDTH-1:0] rot_out;
   logic [WIDTH-1:0] data_arr [NREQ];
   logic [SHW-1:0]   amt_arr  [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
         assign amt_arr[gi]   = req_amt[gi*SHW +: SHW];
         assign req_ready[gi] = take && (grant_id == IDW'(gi));
      end
   endgenerate

   // Gated by rst_n so no grant can leak out while reset is held.
   assign accept = rst_n && ((state_reg == IDLE) || ((state_reg == HOLD) && rsp_ready));
   assign take   = accept && grant_any;

   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
`ifdef BARREL_SHIFT_ARB_FIXED_PRIO_EN
      // Descending scan so the lowest valid index is the last writer.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[IDW'(i)]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(i);
         end
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         int             idx;
         logic [IDW-1:0] cand;
         idx = int'(rr_ptr_reg) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IDW'(idx);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
`endif
   end

   rot_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_rot_core (
      .din  (op_reg),
      .amt  (amt_reg),
      .dout (rot_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         op_reg        <= '0;
         amt_reg       <= '0;
         id_reg        <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_id_reg    <= '0;
`ifndef BARREL_SHIFT_ARB_FIXED_PRIO_EN
         rr_ptr_reg    <= '0;
`endif
      end else begin
         if (take) begin
            op_reg  <= data_arr[grant_id];
            amt_reg <= amt_arr[grant_id];
            id_reg  <= grant_id;
`ifndef BARREL_SHIFT_ARB_FIXED_PRIO_EN
            rr_ptr_reg <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
         end
         case (state_reg)
            IDLE: begin
               if (take) state_reg <= EXEC;
            end
            EXEC: begin
               rsp_data_reg  <= rot_out;
               rsp_id_reg    <= id_reg;
               rsp_valid_reg <= 1'b1;
               state_reg     <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  rsp_valid_reg <= 1'b0;
                  state_reg     <= take ? EXEC : IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_data  = rsp_data_reg;
   assign rsp_id    = rsp_id_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Self-checking bench for barrel_shift_arb: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_barrel_shift_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_data = '0;
   logic [11:0] req_amt = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [7:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        busy;

   always #5 clk = ~clk;

   barrel_shift_arb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: stage 0 = nothing in flight, 1 = operand captured,
   // 2 = result presented to the consumer.
   int         m_stage = 0;
   int         m_ptr   = 0;
   int         m_op    = 0;
   int         m_amt   = 0;
   int         m_id    = 0;
   int         m_data  = 0;
   int         m_rid   = 0;

   bit         rec_en = 1'b0;
   int         obs_id[$];
   int         obs_data[$];

   typedef struct {
      logic [7:0] data;
      logic [2:0] amt;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rot_ref(input int x, input int n);
      return ((x << n) | (x >> (8 - n))) & 255;
   endfunction

   function automatic int pick(input logic [3:0] v, input int ptr);
`ifdef BARREL_SHIFT_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (v[i]) return i + 0 * ptr;
`else
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (ptr + k) % 4;
         if (v[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   // One clock cycle: inputs are already driven; compare just after the
   // falling edge, advance the model across the next rising edge.
   task automatic cycle();
      int  w;
      int  exp_ready;
      bit  accepting;
      logic [31:0] dsh;
      logic [11:0] ash;
      #1;
      if (!rst_n) begin
         m_stage = 0; m_ptr = 0; m_data = 0; m_rid = 0;
      end
      accepting = rst_n && ((m_stage == 0) || ((m_stage == 2) && rsp_ready));
      w = pick(req_valid, m_ptr);
      exp_ready = (accepting && w >= 0) ? (1 << w) : 0;
      chk("req_ready", int'(req_ready), exp_ready);
      chk("rsp_valid", int'(rsp_valid), (m_stage == 2) ? 1 : 0);
      chk("rsp_data",  int'(rsp_data),  m_data);
      chk("rsp_id",    int'(rsp_id),    m_rid);
      chk("busy",      int'(busy),      (m_stage != 0) ? 1 : 0);
      if (rec_en && rsp_valid) begin
         obs_id.push_back(int'(rsp_id));
         obs_data.push_back(int'(rsp_data));
      end
      if (rst_n) begin
         if (m_stage == 1) begin
            m_data  = rot_ref(m_op, m_amt);
            m_rid   = m_id;
            m_stage = 2;
         end else if (accepting) begin
            if (w >= 0) begin
               dsh = req_data >> (w * 8);
               ash = req_amt >> (w * 3);
               m_op    = int'(dsh[7:0]);
               m_amt   = int'(ash[2:0]);
               m_id    = w;
               m_stage = 1;
               m_ptr   = (w + 1) % 4;
            end else begin
               m_stage = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{8'b01001100, 3'd1, 8'b10011000};
      tbl[1] = '{8'b01001100, 3'd0, 8'b01001100};
      tbl[2] = '{8'b01001100, 3'd2, 8'b00110001};
      tbl[3] = '{8'b01001100, 3'd3, 8'b01100010};
      tbl[4] = '{8'b01001100, 3'd5, 8'b10001001};
      tbl[5] = '{8'b01001100, 3'd7, 8'b00100110};

      // Reset with every requester asserting valid.
      req_valid = 4'b1111;
      req_data  = 32'h44332211;
      req_amt   = 12'o3210;
      @(negedge clk);
      #1;
      chk("reset_ready", int'(req_ready), 0);
      chk("reset_valid", int'(rsp_valid), 0);
      chk("reset_data",  int'(rsp_data), 0);
      chk("reset_busy",  int'(busy), 0);
      cycle();
      rst_n = 1'b1;
      #1;
      chk("first_grant", int'(req_ready), 1);
      cycle();
      req_valid = 4'b0000;
      rsp_ready = 1'b1;
      repeat (3) cycle();

      // Table-driven single requests on requester 0.
      for (int t = 0; t < 6; t++) begin
         req_valid     = 4'b0001;
         req_data[7:0] = tbl[t].data;
         req_amt[2:0]  = tbl[t].amt;
         rsp_ready     = 1'b1;
         cycle();
         req_valid = 4'b0000;
         cycle();
         #1;
         chk("tbl_data", int'(rsp_data), int'(tbl[t].exp));
         chk("tbl_id",   int'(rsp_id), 0);
         cycle();
         cycle();
      end

      // All four requesters active: grant order and rotated values.
      do_reset();
      req_valid = 4'b1111;
      req_data  = 32'h01010101;
      req_amt   = {3'd3, 3'd2, 3'd1, 3'd0};
      rsp_ready = 1'b1;
      obs_id.delete();
      obs_data.delete();
      rec_en = 1'b1;
      repeat (12) cycle();
      rec_en = 1'b0;
      req_valid = 4'b0000;
      repeat (3) cycle();
      chk("rr_count_ok", (obs_id.size() >= 5) ? 1 : 0, 1);
      if (obs_id.size() >= 5) begin
         for (int i = 0; i < 5; i++) begin
`ifdef BARREL_SHIFT_ARB_FIXED_PRIO_EN
            chk("rr_id", obs_id[i], 0);
            chk("rr_data", obs_data[i], 1);
`else
            chk("rr_id", obs_id[i], i % 4);
            chk("rr_data", obs_data[i], 1 << (i % 4));
`endif
         end
      end

      // Backpressure in HOLD with requester 1 waiting.
      do_reset();
      req_valid = 4'b0001;
      req_data  = 32'h0000_00A5;
      req_amt   = 12'd3;
      rsp_ready = 1'b0;
      cycle();
      req_valid = 4'b0010;
      cycle();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_ready", int'(req_ready), 0);
         chk("bp_data",  int'(rsp_data), 8'h2D);
         chk("bp_id",    int'(rsp_id), 0);
         cycle();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_grant1", int'(req_ready), 2);
      cycle();
      req_valid = 4'b0000;
      repeat (4) cycle();

      // Reset asserted while an operation is in EXEC.
      req_valid = 4'b0001;
      req_data  = 32'h0000_00FF;
      rsp_ready = 1'b1;
      cycle();
      req_valid = 4'b0000;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(rsp_valid), 0);
      chk("midrst_busy",  int'(busy), 0);
      chk("midrst_data",  int'(rsp_data), 0);
      cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("midrst_stale", int'(rsp_valid), 0);
         cycle();
      end

      // Requester 2 raises then drops valid before it is granted.
      obs_id.delete();
      obs_data.delete();
      rec_en = 1'b1;
      req_valid = 4'b0001;
      req_data  = 32'h0000_0011;
      rsp_ready = 1'b0;
      cycle();
      req_valid = 4'b0100;
      cycle();
      cycle();
      req_valid = 4'b0000;
      cycle();
      rsp_ready = 1'b1;
      repeat (4) cycle();
      rec_en = 1'b0;
      chk("drop_seen", (obs_id.size() > 0) ? 1 : 0, 1);
      foreach (obs_id[i]) chk("drop_id_not2", (obs_id[i] == 2) ? 1 : 0, 0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         req_valid = 4'($urandom_range(0, 15));
         req_data  = $urandom;
         req_amt   = 12'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 99) != 0);
         cycle();
      end
      rst_n = 1'b1;
      req_valid = 4'b0000;
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/barrel_shift_arb.md
Name: barrel_shift_arb

Overview:
- Shares one combinational 8-bit rotate-left barrel shifter between NREQ requesters.
- Each requester presents an operand and a rotate amount on a valid/ready handshake.
- The block arbitrates, sequences operand capture, the shift, and result hand-off, then returns the result tagged with the requester index.
- Sits between client blocks and the shared shifter resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- SHW, 3, rotate-amount width; equals log2(WIDTH).
- IDW, 2, requester-index width; equals log2(NREQ) (minimum 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_data  in  NREQ*WIDTH  operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_amt  in  NREQ*SHW  rotate amounts; requester i uses bits [i*SHW +: SHW].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  rotated result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, rr_ptr=0.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - If any req_valid is set, assert req_ready combinationally for exactly one winner i.
  - On that edge, capture op_reg<=data_i, amt_reg<=amt_i, id_reg<=i; go to EXEC.
  - Otherwise stay in IDLE with req_ready=0.
- EXEC: rsp_data<=rotl(op_reg, amt_reg), rsp_id<=id_reg, rsp_valid<=1; go to HOLD.
- HOLD:
  - rsp_valid=1; rsp_data and rsp_id stay stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid<=0.
  - If any req_valid is also set that cycle, grant the next winner in the same cycle (back-to-back) and go to EXEC; otherwise go to IDLE.
- Latency: grant edge -> rsp_valid high 2 cycles later. Sustained throughput: 1 result per 2 cycles.
- Rotate: rotl(x,n) = (x<<n)|(x>>(WIDTH-n)) taken to WIDTH bits; n=0 passes x unchanged; no bits are lost.
- Handshake rules:
  - req_ready is never asserted outside IDLE or an accepting HOLD cycle.
  - At most one req_ready bit is high per cycle.
  - A requester may drop req_valid without penalty when not granted.
- Round-robin arbitration: search starts at rr_ptr and wraps modulo NREQ. After a grant to i, rr_ptr<=(i+1) mod NREQ. With all requesters active, grants follow 0,1,2,3,0...
- A request arriving in EXEC waits; it is not lost.
- rst_n asserted mid-operation aborts the in-flight op immediately; no response is produced after release.
- req_amt wider values cannot occur, since width is SHW by construction.

Optional Feature:
- Macro: BARREL_SHIFT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined (default): round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Shared package barrel_shift_pkg holds:
  - state encoding IDLE=2'd0, EXEC=2'd1, HOLD=2'd2;
  - default widths WIDTH_D=8, SHW_D=3;
  - function rotl(WIDTH, SHW).
- One sub-module, rot_core: purely combinational WIDTH-bit rotate-left (in, amt -> out), instantiated once inside the arbiter. Arbiter logic stays in the top module.

Test Plan:
- Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rsp_data=0, busy=0. Release -> first grant goes to requester 0.
- Single request: req0 data=8'b01001100, amt=1, rsp_ready=1 -> 2 cycles after grant, rsp_data=8'b10011000, rsp_id=0. Repeat with amt=0/2/3/5/7 -> 01001100 / 00110001 / 01100010 / 10001001 / 00100110.
- Round robin: all four valid, data_i=8'h01, amt_i=i -> rsp_id order 0,1,2,3,0; rsp_data 01,02,04,08. With FIXED_PRIO_EN the order is 0,0,0...
- Backpressure: rsp_ready=0 for 5 cycles in HOLD -> rsp_data/rsp_id stable, req_ready=0. Raise rsp_ready with req1 pending -> req_ready[1] asserted in the same cycle.
- Reset mid-op: assert rst_n=0 during EXEC -> outputs zero asynchronously; no stale rsp_valid after release.
- Drop request: req2 asserts valid then deasserts before grant -> no response carries rsp_id=2.
